// File: rtl/execute_muldiv_sequencer.sv
// execute_muldiv_sequencer
//   Iterative unsigned multiply / divide unit that sits beside the ALU in the
//   execute stage. An M-type op is accepted from E, the pipeline is stalled
//   while the engine iterates one bit per cycle, and the result is presented
//   for exactly one DONE cycle (longer while the memory stage holds).
//
// Ports
//   i_Clk        clock, rising edge
//   i_Reset      asynchronous reset, active low
//   i_StartE     E-stage instruction is a mul/div op
//   i_MDOpE      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   i_SrcAE      multiplicand / dividend (sampled only at accept)
//   i_SrcBE      multiplier / divisor    (sampled only at accept)
//   i_FlushE     E-stage flush; beats accept, iteration and hold
//   i_HoldM      downstream hold; keeps DONE and the result
//   o_StallMD    stall request for F/D/E
//   o_BusyMD     high in BUSY or DONE
//   o_DoneMD     result valid this cycle
//   o_MDResultE  result, meaningful only while o_DoneMD is high
module execute_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_StartE,
    input  logic [1:0]      i_MDOpE,
    input  logic [XLEN-1:0] i_SrcAE,
    input  logic [XLEN-1:0] i_SrcBE,
    input  logic            i_FlushE,
    input  logic            i_HoldM,
    output logic            o_StallMD,
    output logic            o_BusyMD,
    output logic            o_DoneMD,
    output logic [XLEN-1:0] o_MDResultE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          op;
    // Multiply: 2*XLEN multiplicand shifted left each step.
    // Divide:   low half holds the dividend, shifting out MSB-first while
    //           quotient bits shift in from the bottom.
    logic [2*XLEN-1:0]   a_sh;
    logic [XLEN-1:0]     b_sh;      // multiplier (shifts right) / divisor (static)
    logic [2*XLEN-1:0]   acc;       // product accumulator
    logic [XLEN:0]       rem;       // partial remainder
    logic [XLEN-1:0]     result;

    logic                is_div;
    logic                accept;
    logic                last_iter;

    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   a_mul_next;
    logic [XLEN-1:0]     b_mul_next;
    logic [XLEN+1:0]     shifted;
    logic [XLEN+1:0]     trial;
    logic                q_bit;
    logic [XLEN:0]       rem_next;
    logic [XLEN-1:0]     quo_next;
    logic [XLEN-1:0]     res_final;

    assign is_div    = op[1];
    assign accept    = (state == IDLE) && i_StartE && !i_FlushE;
    assign last_iter = (cnt == CNT_W'(XLEN-1));

    // Stall is combinational in the accept cycle so the instruction stays in E.
    // Gated by reset so a held-high start cannot stall the pipe during reset.
    assign o_StallMD   = i_Reset && (accept || (state == BUSY));
    assign o_BusyMD    = (state != IDLE);
    assign o_DoneMD    = (state == DONE) && !i_FlushE;
    assign o_MDResultE = result;

    // One iteration of both datapaths; the FSM commits only the one in use.
    always_comb begin
        acc_next   = acc + (b_sh[0] ? a_sh : '0);
        a_mul_next = {a_sh[2*XLEN-2:0], 1'b0};
        b_mul_next = {1'b0, b_sh[XLEN-1:1]};

        // Restoring step: bring down the next dividend bit, try a subtract,
        // keep it only if it did not go negative (top bit of the wider diff).
        shifted  = {rem, a_sh[XLEN-1]};
        trial    = shifted - {2'b00, b_sh};
        q_bit    = !trial[XLEN+1];
        rem_next = q_bit ? trial[XLEN:0] : shifted[XLEN:0];
        quo_next = {a_sh[XLEN-2:0], q_bit};

        case (op)
            2'b00:   res_final = acc_next[XLEN-1:0];
            2'b01:   res_final = acc_next[2*XLEN-1:XLEN];
            2'b10:   res_final = quo_next;
            default: res_final = rem_next[XLEN-1:0];
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op   <= i_MDOpE;
                        a_sh <= {{XLEN{1'b0}}, i_SrcAE};
                        b_sh <= i_SrcBE;
                        acc  <= '0;
                        rem  <= '0;
                        cnt  <= '0;
                        if (i_MDOpE[1] && (i_SrcBE == '0)) begin
                            // Divide by zero resolves without iterating.
                            result <= i_MDOpE[0] ? i_SrcAE : '1;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (i_FlushE) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            rem              <= rem_next;
                            a_sh[XLEN-1:0]   <= quo_next;
                        end else begin
                            acc  <= acc_next;
                            a_sh <= a_mul_next;
                            b_sh <= b_mul_next;
                        end
                        if (last_iter) begin
                            result <= res_final;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_FlushE || !i_HoldM)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
module tb_execute_muldiv_sequencer;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic        i_StartE = 1'b0;
    logic [1:0]  i_MDOpE = 2'b00;
    logic [31:0] i_SrcAE = '0;
    logic [31:0] i_SrcBE = '0;
    logic        i_FlushE = 1'b0;
    logic        i_HoldM = 1'b0;
    logic        o_StallMD;
    logic        o_BusyMD;
    logic        o_DoneMD;
    logic [31:0] o_MDResultE;

    int checks = 0;
    int failures = 0;

    execute_muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_StartE    (i_StartE),
        .i_MDOpE     (i_MDOpE),
        .i_SrcAE     (i_SrcAE),
        .i_SrcBE     (i_SrcBE),
        .i_FlushE    (i_FlushE),
        .i_HoldM     (i_HoldM),
        .o_StallMD   (o_StallMD),
        .o_BusyMD    (o_BusyMD),
        .o_DoneMD    (o_DoneMD),
        .o_MDResultE (o_MDResultE)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural definition.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_StartE = 1'b1;
        i_MDOpE  = op;
        i_SrcAE  = a;
        i_SrcBE  = b;
    endtask

    // Called at a negedge with the op already driven; returns at a negedge.
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold_cycles, input bit chain,
                       input logic [1:0] nop, input logic [31:0] na, input logic [31:0] nb,
                       input bit scramble);
        int cyc = 0;
        int stalls = 0;
        bit seen = 0;
        logic [31:0] exp_res;
        int exp_st;
        exp_res = model(op, a, b);
        exp_st  = (op[1] && b == 0) ? 1 : 33;
        while (cyc < 80 && !seen) begin
            #2;
            cyc++;
            if (o_DoneMD) begin
                seen = 1;
            end else begin
                if (o_StallMD) stalls++;
                @(negedge i_Clk);
                if (scramble) begin
                    i_SrcAE = $urandom;
                    i_SrcBE = $urandom;
                    i_MDOpE = 2'($urandom_range(0, 3));
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!seen) begin
            i_StartE = 1'b0;
            @(negedge i_Clk);
            return;
        end
        chk({tag, "_stall_cycles"}, stalls, exp_st);
        chk({tag, "_done_cycle"}, cyc, exp_st + 1);
        chk({tag, "_result"}, o_MDResultE, exp_res);
        chk({tag, "_stall_in_done"}, 32'(o_StallMD), 32'd0);
        if (hold_cycles > 0) i_HoldM = 1'b1;
        if (chain) issue(nop, na, nb);
        else       i_StartE = 1'b0;
        for (int k = 1; k <= hold_cycles; k++) begin
            @(negedge i_Clk);
            if (k == hold_cycles) i_HoldM = 1'b0;
            #2;
            chk({tag, "_hold_done"}, 32'(o_DoneMD), 32'd1);
            chk({tag, "_hold_result"}, o_MDResultE, exp_res);
            chk({tag, "_hold_stall"}, 32'(o_StallMD), 32'd0);
        end
        @(negedge i_Clk);
        if (!chain) begin
            #2;
            chk({tag, "_after_done"}, 32'(o_DoneMD), 32'd0);
            chk({tag, "_after_busy"}, 32'(o_BusyMD), 32'd0);
            @(negedge i_Clk);
        end
    endtask

    logic [1:0]  rop [0:20];
    logic [31:0] ra  [0:20];
    logic [31:0] rb  [0:20];

    initial begin
        int dcount;
        // Reset state
        repeat (2) @(negedge i_Clk);
        #2;
        chk("rst_stall", 32'(o_StallMD), 32'd0);
        chk("rst_busy", 32'(o_BusyMD), 32'd0);
        chk("rst_done", 32'(o_DoneMD), 32'd0);
        chk("rst_result", o_MDResultE, 32'd0);
        @(negedge i_Clk);
        i_Reset = 1'b1;
        @(negedge i_Clk);

        // Directed ops
        issue(2'd0, 32'd7, 32'd6);
        run("mul7x6", 2'd0, 32'd7, 32'd6, 0, 0, 2'd0, 0, 0, 0);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run("mul_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'd0, 0, 0, 0);
        issue(2'd2, 32'd100, 32'd7);
        run("divu100_7", 2'd2, 32'd100, 32'd7, 0, 1, 2'd3, 32'd100, 32'd7, 0);
        run("remu100_7", 2'd3, 32'd100, 32'd7, 0, 1, 2'd2, 32'h8000_0000, 32'd1, 0);
        run("divu_msb_1", 2'd2, 32'h8000_0000, 32'd1, 0, 0, 2'd0, 0, 0, 0);
        issue(2'd2, 32'd123, 32'd0);
        run("divu_by0", 2'd2, 32'd123, 32'd0, 0, 1, 2'd3, 32'd123, 32'd0, 0);
        run("remu_by0", 2'd3, 32'd123, 32'd0, 0, 0, 2'd0, 0, 0, 0);

        // Flush during BUSY
        issue(2'd0, 32'd5, 32'd5);
        #2;
        chk("flush_accept_stall", 32'(o_StallMD), 32'd1);
        repeat (10) @(negedge i_Clk);
        i_FlushE = 1'b1;
        #2;
        chk("flush_busy_before", 32'(o_BusyMD), 32'd1);
        @(negedge i_Clk);
        i_FlushE = 1'b0;
        i_StartE = 1'b0;
        #2;
        chk("flush_stall_after", 32'(o_StallMD), 32'd0);
        chk("flush_busy_after", 32'(o_BusyMD), 32'd0);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_Clk);
            #2;
            if (o_DoneMD) dcount++;
        end
        chk("flush_no_done", dcount, 0);
        @(negedge i_Clk);

        // Flush with start in IDLE: no accept
        i_StartE = 1'b1;
        i_FlushE = 1'b1;
        #2;
        chk("flush_idle_stall", 32'(o_StallMD), 32'd0);
        @(negedge i_Clk);
        i_StartE = 1'b0;
        i_FlushE = 1'b0;
        #2;
        chk("flush_idle_busy", 32'(o_BusyMD), 32'd0);
        @(negedge i_Clk);

        // Asynchronous reset mid-operation
        issue(2'd0, 32'd5, 32'd9);
        repeat (21) @(negedge i_Clk);
        i_Reset = 1'b0;
        #1;
        chk("arst_stall", 32'(o_StallMD), 32'd0);
        chk("arst_busy", 32'(o_BusyMD), 32'd0);
        chk("arst_done", 32'(o_DoneMD), 32'd0);
        chk("arst_result", o_MDResultE, 32'd0);
        @(negedge i_Clk);
        i_Reset = 1'b1;
        i_StartE = 1'b0;
        @(negedge i_Clk);
        issue(2'd0, 32'd3, 32'd4);
        run("mul3x4_hold", 2'd0, 32'd3, 32'd4, 3, 0, 2'd0, 0, 0, 0);

        // Randomized ops, chained back-to-back at random, with operand and
        // op-code churn on the forwarding inputs while iterating
        for (int i = 0; i <= 20; i++) begin
            rop[i] = 2'($urandom_range(0, 3));
            ra[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 4))
                0:       rb[i] = 32'd0;
                1:       rb[i] = 32'($urandom_range(1, 15));
                default: rb[i] = $urandom;
            endcase
        end
        issue(rop[0], ra[0], rb[0]);
        for (int i = 0; i < 20; i++) begin
            bit ch;
            ch = (i < 19) && ($urandom_range(0, 1) == 1);
            run($sformatf("rnd%0d_op%0d", i, rop[i]), rop[i], ra[i], rb[i],
                ($urandom_range(0, 3) == 0) ? 2 : 0, ch, rop[i+1], ra[i+1], rb[i+1], 1);
            if (!ch) issue(rop[i+1], ra[i+1], rb[i+1]);
        end
        i_StartE = 1'b0;
        @(negedge i_Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_sequencer.md
Name: execute_muldiv_sequencer

Overview:
- Iterative 32-bit multiply/divide engine plus its control FSM, sitting beside the ALU in the execute stage.
- Accepts a M-type op from the execute register, requests a stall from the hazard unit while iterating, and presents the result in a single DONE cycle.
- The execute-stage result mux then selects the result toward the memory stage.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
- i_Clk  input  1  clock; all state updates on rising edge.
- i_Reset  input  1  asynchronous, active-low reset.
- i_StartE  input  1  execute-stage instruction is a mul/div op.
- i_MDOpE  input  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- i_SrcAE  input  XLEN  forwarded operand A (multiplicand/dividend).
- i_SrcBE  input  XLEN  forwarded operand B (multiplier/divisor).
- i_FlushE  input  1  execute-stage flush from hazard unit.
- i_HoldM  input  1  downstream hold; DONE state is retained while high.
- o_StallMD  output  1  stall request to hazard unit (stall F, D, E).
- o_BusyMD  output  1  high in BUSY or DONE.
- o_DoneMD  output  1  result valid this cycle.
- o_MDResultE  output  XLEN  result; valid only when o_DoneMD is high.

Behaviour:
- Reset (i_Reset low, asynchronous):
  - state=IDLE; counter, operand, accumulator and result registers = 0.
  - o_StallMD=0, o_BusyMD=0, o_DoneMD=0, o_MDResultE=0.
  - Reset mid-operation discards the operation with no done pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when i_StartE=1 and i_FlushE=0.
  - o_StallMD=1 combinationally in the accept cycle, so the instruction holds in E.
  - On the accept edge: latch i_SrcAE, i_SrcBE and i_MDOpE; clear the accumulator; counter=0.
  - If the op is DIVU/REMU and i_SrcBE==0, go directly to DONE. Otherwise go to BUSY.
- BUSY:
  - o_StallMD=1; one iteration per cycle; counter increments.
  - When counter==XLEN-1, the last iteration completes and the next state is DONE.
  - Exactly 32 BUSY cycles.
- Multiply:
  - Unsigned shift-add into a 64-bit product, LSB-first over the multiplier.
  - MUL returns product[31:0]; MULHU returns product[63:32].
- Divide:
  - Restoring division, MSB-first. Remainder register is 33 bits wide for trial subtraction.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: quotient=32'hFFFFFFFF, remainder=dividend. Exactly 1 stall cycle.
- DONE:
  - o_DoneMD=1, o_StallMD=0, o_MDResultE stable; the instruction advances E->M at this edge.
  - If i_HoldM=1, stay in DONE with the result held and stall still 0.
  - Otherwise return to IDLE. IDLE re-evaluates i_StartE the following cycle, so there is no restart of the completed instruction.
- Latency:
  - Normal op: stall asserted for 33 consecutive cycles (accept + 32 BUSY); o_DoneMD in the 34th cycle.
  - Divide by zero: stall for 1 cycle; done in the 2nd cycle.
- Flush:
  - i_FlushE=1 in BUSY or DONE: next state IDLE, o_DoneMD not asserted, o_StallMD drops the cycle after the flush edge.
  - i_FlushE=1 with i_StartE=1 in IDLE: no accept, and o_StallMD=0.
  - Flush has priority over accept, iteration and hold.
- Operands are sampled only at accept. Changes on i_SrcAE/i_SrcBE during BUSY (forwarding-path changes) must not affect the result.
- Back-to-back ops:
  - A new op in E in the cycle after DONE is accepted normally.
  - No idle bubble is required beyond that cycle.
- i_MDOpE value change during BUSY is ignored.

Test Plan:
- MUL, A=7, B=6 -> o_StallMD high for exactly 33 cycles; o_DoneMD for 1 cycle with o_MDResultE=42.
- MULHU, A=B=32'hFFFFFFFF -> result 32'hFFFFFFFE; MUL with the same operands -> 32'h00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 32'h80000000/1 -> 32'h80000000.
- DIVU 123/0 -> 32'hFFFFFFFF and REMU 123/0 -> 123, each with 1 stall cycle and done in the 2nd cycle.
- MUL 5*5 with i_FlushE pulsed at BUSY cycle 10 -> IDLE next cycle; no o_DoneMD; stall low.
- i_Reset low at BUSY cycle 20 -> all outputs 0 immediately (async). After release, MUL 3*4 gives 12, and i_HoldM=1 for 3 cycles in DONE keeps o_DoneMD=1 and result=12 for 4 cycles.
